// File: rtl/cpu_run_ctrl_if.sv
// Bundle between the run/step controller and its environment: board switches,
// push-button, 1 s tick and breakpoint setup on the input side, plus the CPU
// clock-enable, PC feedback and status outputs.
// The controller connects through the slave modport. The board/CPU side
// connects through the master modport.
interface cpu_run_ctrl_if;
  logic        tick_1s;
  logic [1:0]  mode_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_in;
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] ce_count;

  modport slave (
    input  tick_1s,
    input  mode_sw,
    input  step_btn,
    input  bp_en,
    input  bp_addr,
    input  pc_in,
    output cpu_ce,
    output halted,
    output state,
    output ce_count
  );

  modport master (
    output tick_1s,
    output mode_sw,
    output step_btn,
    output bp_en,
    output bp_addr,
    output pc_in,
    input  cpu_ce,
    input  halted,
    input  state,
    input  ce_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller for the pipelined CPU. It produces a
// one-cycle clock-enable (cpu_ce) that advances the CPU. Supported modes are
// halt, single-step from a debounced button, run paced by the 1 s tick, and
// fast run at one pulse every two cycles. A PC breakpoint can stop execution.
//
// Optional build macro CPU_RUN_CTRL_CE_COUNT_EN:
// - defined: ce_count is a 32-bit wrapping count of issued cpu_ce pulses.
// - undefined: no counter is built, and ce_count reads 0.
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_CNT_W        = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam logic [1:0]          MODE_HALT = 2'b00;
  localparam logic [1:0]          MODE_STEP = 2'b01;
  localparam logic [1:0]          MODE_FAST = 2'b11;
  localparam logic [DB_CNT_W-1:0] DB_LAST   = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizer stages. _p1 is the only copy that the logic may use.
  logic [1:0]          mode_p0;
  logic [1:0]          mode_p1;
  logic                btn_p0;
  logic                btn_p1;

  // Debounce
  logic [DB_CNT_W-1:0] db_cnt;
  logic                db_lvl;
  logic                db_lvl_d;
  logic                step_req;

  // Control FSM
  state_e              state_q;
  state_e              state_d;
  logic                ce_q;
  logic                ce_d;
  logic                halted_q;
  logic                halted_d;
  logic                fire_ok;
  logic                run_req;
  logic                bp_hit;

  // ---- stage p0 -> p1: two-flop synchronizers for the asynchronous board inputs
  // Synchronize the raw switches and button into clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_p0 <= 2'b00;
      mode_p1 <= 2'b00;
      btn_p0  <= 1'b0;
      btn_p1  <= 1'b0;
    end else begin
      mode_p0 <= bus.mode_sw;
      mode_p1 <= mode_p0;
      btn_p0  <= bus.step_btn;
      btn_p1  <= btn_p0;
    end
  end

  // ---- debounce: accept a new button level only after it has been stable
  // Count consecutive cycles where the synchronized button disagrees with the
  // accepted level. Any agreeing sample (a bounce back) restarts the count.
  // db_lvl_d keeps the previous accepted level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_lvl   <= 1'b0;
      db_lvl_d <= 1'b0;
    end else begin
      db_lvl_d <= db_lvl;
      if (btn_p1 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= btn_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_CNT_W'(1);
      end
    end
  end

  // A press (debounced rising edge) is a single-cycle step request. Release is ignored.
  assign step_req = db_lvl & ~db_lvl_d;

  // The previous cycle's pulse blocks this one. Pulses are therefore always
  // separated, and pc_in has settled before the breakpoint compare below.
  assign fire_ok  = ~ce_q;

  // Fast run asks every cycle. Slow run asks only on the tick.
  assign run_req  = (mode_p1 == MODE_FAST) | bus.tick_1s;

  assign bp_hit   = bus.bp_en & (bus.pc_in == bus.bp_addr);

  // Next-state and advance-request decision.
  always_comb begin
    state_d  = state_q;
    ce_d     = 1'b0;
    halted_d = 1'b0;
    if (mode_p1 == MODE_HALT) begin
      // Halt overrides everything, including a pending step request.
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_HALT: begin
          state_d = (mode_p1 == MODE_STEP) ? ST_STEP : ST_RUN;
        end
        ST_STEP: begin
          ce_d = step_req & fire_ok;
          if (mode_p1[1]) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (mode_p1 == MODE_STEP) begin
            state_d = ST_STEP;
          end else if (run_req && fire_ok) begin
            // A tick arriving while blocked is dropped, not queued.
            if (bp_hit) state_d = ST_BREAK;
            else        ce_d    = 1'b1;
          end
        end
        ST_BREAK: begin
          // A press steps past the breakpoint PC with no compare. The state then
          // follows the mode switch.
          if (step_req && fire_ok) begin
            ce_d    = 1'b1;
            state_d = mode_p1[1] ? ST_RUN : ST_STEP;
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
    halted_d = (state_d == ST_HALT) | (state_d == ST_BREAK);
  end

  // ---- decision -> registered outputs
  // Register the state, the status flag and the one-cycle clock-enable together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HALT;
      ce_q     <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ce_q     <= ce_d;
      halted_q <= halted_d;
    end
  end

  assign bus.cpu_ce = ce_q;
  assign bus.halted = halted_q;
  assign bus.state  = state_q;

`ifdef CPU_RUN_CTRL_CE_COUNT_EN
  logic [31:0] ce_cnt_q;

  // Count issued pulses. The count wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ce_cnt_q <= 32'h0;
    else if (ce_q) ce_cnt_q <= ce_cnt_q + 32'd1;
  end

  assign bus.ce_count = ce_cnt_q;
`else
  assign bus.ce_count = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. The bench runs directed scenarios (reset,
// bouncy step, slow run, fast run into a breakpoint, resume past the
// breakpoint, halt override, reset mid-run) followed by a randomized phase.
// Every cycle, the outputs are compared with a behavioural model of the
// run/step/break rules.
module tb_cpu_run_ctrl;
  localparam int N_DB    = 8;
  localparam int S_HALT  = 0;
  localparam int S_STEP  = 1;
  localparam int S_RUN   = 2;
  localparam int S_BREAK = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(N_DB), .DB_CNT_W(18)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  bit pc_follow = 1'b0;

  // Reference model: what the controller should be doing, from the rules
  int          m_state;
  bit          m_ce;
  logic [31:0] m_count;
  bit          m_lvl;        // accepted (debounced) button level
  bit          m_sreq;       // press seen, usable by the next decision
  logic [1:0]  mode_q[$];    // raw switch samples still in flight to the logic
  bit          btn_q[$];     // raw button samples still in flight
  bit          win[$];       // most recent synchronized button samples

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
`ifdef CPU_RUN_CTRL_CE_COUNT_EN
    return m_count;
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_state = S_HALT;
    m_ce    = 1'b0;
    m_count = 32'h0;
    m_lvl   = 1'b0;
    m_sreq  = 1'b0;
    mode_q  = {2'b00, 2'b00};
    btn_q   = {1'b0, 1'b0};
    win.delete();
  endtask

  // One clock edge of intended behaviour, using the inputs present at the edge.
  task automatic model_edge();
    logic [1:0] md;
    bit sb, want, fire_ok, hit, all_diff;
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // Board inputs reach the logic two samples late.
    md = mode_q.pop_front();
    mode_q.push_back(bus.mode_sw);
    sb = btn_q.pop_front();
    btn_q.push_back(bus.step_btn);

    want    = 1'b0;
    nxt     = m_state;
    fire_ok = !m_ce;
    hit     = bus.bp_en && (bus.pc_in == bus.bp_addr);
    if (md == 2'b00) nxt = S_HALT;
    else if (m_state == S_HALT) nxt = (md == 2'b01) ? S_STEP : S_RUN;
    else if (m_state == S_STEP) begin
      want = m_sreq && fire_ok;
      if (md[1]) nxt = S_RUN;
    end else if (m_state == S_RUN) begin
      if (md == 2'b01) nxt = S_STEP;
      else if (fire_ok && (md == 2'b11 || bus.tick_1s)) begin
        if (hit) nxt = S_BREAK;
        else     want = 1'b1;
      end
    end else begin
      if (m_sreq && fire_ok) begin
        want = 1'b1;
        nxt  = md[1] ? S_RUN : S_STEP;
      end
    end
    if (m_ce) m_count = m_count + 32'd1;
    m_ce    = want;
    m_state = nxt;

    // New level is accepted once the last N_DB synchronized samples all disagree with it.
    win.push_back(sb);
    if (win.size() > N_DB) void'(win.pop_front());
    all_diff = (win.size() == N_DB);
    foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
    m_sreq = 1'b0;
    if (all_diff) begin
      m_lvl  = ~m_lvl;
      m_sreq = m_lvl;
    end
  endtask

  task automatic cyc();
    bit ce_seen;
    @(posedge clk);
    ce_seen = bus.cpu_ce;
    model_edge();
    #1;
    if (bus.cpu_ce === 1'b1) pulses++;
    check("cpu_ce",   32'(bus.cpu_ce),   32'(m_ce));
    check("state",    32'(bus.state),    32'(m_state));
    check("halted",   32'(bus.halted),   32'(m_state == S_HALT || m_state == S_BREAK));
    check("ce_count", bus.ce_count,      exp_count());
    // The CPU advances its PC on each enable.
    if (pc_follow && ce_seen) bus.pc_in = bus.pc_in + 32'd4;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  initial begin
    int p0;
    bus.tick_1s  = 1'b0;
    bus.mode_sw  = 2'b00;
    bus.step_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;
    bus.pc_in    = 32'h0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ce",   32'(bus.cpu_ce), 32'd0);
    check("rst_state",    32'(bus.state),  32'd0);
    check("rst_halted",   32'(bus.halted), 32'd1);
    check("rst_ce_count", bus.ce_count,    32'd0);
    rst_n = 1'b1;
    run(4);

    // Bouncy step: only the final stable press produces a pulse
    bus.mode_sw = 2'b01;
    run(4);
    check("step_state", 32'(bus.state), 32'd1);
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      bus.step_btn = ~bus.step_btn;
      run(3);
    end
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    bus.step_btn = 1'b1;
    run(20);
    check("step_one_pulse", 32'(pulses - p0), 32'd1);
    bus.step_btn = 1'b0;
    run(20);
    check("release_no_pulse", 32'(pulses - p0), 32'd1);

    // Slow run: one pulse in the cycle after each tick
    bus.mode_sw = 2'b10;
    run(4);
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      bus.tick_1s = 1'b1;
      cyc();
      bus.tick_1s = 1'b0;
      check("slow_tick_pulse", 32'(bus.cpu_ce), 32'd1);
      cyc();
      check("slow_single", 32'(bus.cpu_ce), 32'd0);
      run(98);
    end
    check("slow_pulses", 32'(pulses - p0), 32'd5);
    check("slow_state",  32'(bus.state),   32'd2);

    // Fast run into the breakpoint at 0x10
    bus.pc_in   = 32'h0;
    bus.bp_addr = 32'h10;
    bus.bp_en   = 1'b1;
    pc_follow   = 1'b1;
    bus.mode_sw = 2'b11;
    p0 = pulses;
    run(24);
    check("bp_pulses", 32'(pulses - p0), 32'd4);
    check("bp_state",  32'(bus.state),   32'd3);
    check("bp_halted", 32'(bus.halted),  32'd1);
    check("bp_pc",     bus.pc_in,        32'h10);

    // Resume: a press steps past the breakpoint, and fast run continues
    bus.step_btn = 1'b1;
    run(30);
    check("resume_state",  32'(bus.state),            32'd2);
    check("resume_passed", 32'(bus.pc_in > 32'h14),   32'd1);
    bus.step_btn = 1'b0;
    run(15);
    bus.bp_en = 1'b0;

    // Halt override together with a press
    bus.mode_sw  = 2'b00;
    bus.step_btn = 1'b1;
    run(3);
    check("halt_state",  32'(bus.state),  32'd0);
    check("halt_halted", 32'(bus.halted), 32'd1);
    p0 = pulses;
    run(25);
    check("halt_no_pulse", 32'(pulses - p0), 32'd0);
    bus.step_btn = 1'b0;
    run(20);

    // Asynchronous reset while pulsing
    bus.mode_sw = 2'b11;
    run(6);
    for (int i = 0; i < 4 && bus.cpu_ce !== 1'b1; i++) cyc();
    check("pre_rst_ce", 32'(bus.cpu_ce), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cpu_ce",   32'(bus.cpu_ce), 32'd0);
    check("arst_state",    32'(bus.state),  32'd0);
    check("arst_halted",   32'(bus.halted), 32'd1);
    check("arst_ce_count", bus.ce_count,    32'd0);
    bus.mode_sw = 2'b00;
    bus.pc_in   = 32'h0;
    run(3);
    rst_n = 1'b1;
    run(10);
    check("post_rst_state", 32'(bus.state), 32'd0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.mode_sw = 2'($urandom_range(0, 3));
        bus.bp_en   = 1'($urandom_range(0, 1));
        bus.bp_addr = 32'($urandom_range(0, 16)) * 32'd4;
      end
      bus.tick_1s = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 24) == 0) bus.step_btn = ~bus.step_btn;
      cyc();
      if (bus.pc_in > 32'h40) bus.pc_in = 32'h0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
